// File: rtl/jt89_noise_lfsr_if.sv
// rtl/jt89_noise_lfsr_if.sv - control and sample bus of the JT89 noise channel
interface jt89_noise_lfsr_if #(
    parameter int OUT_W = 10
);
    logic                    cen;
    logic [2:0]              ctrl3;
    logic                    ctrl_we;
    logic [3:0]              vol;
    logic                    ch2;
    logic signed [OUT_W-1:0] snd;
    logic                    noise_bit;
    logic                    update;

    modport master (
        output cen, ctrl3, ctrl_we, vol, ch2,
        input  snd, noise_bit, update
    );

    modport slave (
        input  cen, ctrl3, ctrl_we, vol, ch2,
        output snd, noise_bit, update
    );
endinterface

// File: rtl/jt89_noise_lfsr.sv
// rtl/jt89_noise_lfsr.sv - parametrised JT89 noise channel: rate divider, LFSR, attenuated output
module jt89_noise_lfsr #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 'h0009,
    parameter logic [LFSR_W-1:0] SEED   = 'h8000,
    parameter int                DIV    = 16,
    parameter int                OUT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jt89_noise_lfsr_if.slave      bus
);
    localparam int CNT_W = $clog2(DIV * 4);

    // 2 dB per step: each attenuation step scales the previous level by 10^(-1/10).
    function automatic logic [16*OUT_W-1:0] build_mag();
        real                  lvl;
        int                   m;
        logic [16*OUT_W-1:0]  t;
        lvl = real'((1 << (OUT_W - 1)) - 1);
        t   = '0;
        for (int v = 0; v < 15; v++) begin
            m = $rtoi(lvl + 0.5);
            t[v*OUT_W +: OUT_W] = OUT_W'(m);
            lvl = lvl * 0.7943282347242815;
        end
        return t;
    endfunction

    localparam logic [16*OUT_W-1:0] MAG_TBL = build_mag();

    logic [LFSR_W-1:0]       shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    update_q, update_d;
    logic                    last_ch2_q;
    logic signed [OUT_W-1:0] snd_q, snd_d;

    logic [1:0]        rate;
    logic              slaved;
    logic              fb;
    logic [CNT_W-1:0]  reload;
    logic [OUT_W-1:0]  mag;

    always_comb begin
        rate     = bus.ctrl3[1:0];
        slaved   = (rate == 2'd3);
        reload   = CNT_W'((DIV << rate) - 1);
        fb       = bus.ctrl3[2] ? ^(shift_q & TAPS) : shift_q[0];
        cnt_d    = cnt_q;
        update_d = 1'b0;
        shift_d  = shift_q;

        if (slaved) begin
            update_d = bus.ch2 & ~last_ch2_q;
        end else if (bus.cen) begin
            if (cnt_q == '0) begin
                cnt_d    = reload;
                update_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // An all-zero register can never leave zero on its own, so it is reseeded.
        if (update_q) begin
            shift_d = (shift_q == '0) ? SEED : {fb, shift_q[LFSR_W-1:1]};
        end

        if (bus.ctrl_we) begin
            shift_d  = SEED;
            cnt_d    = slaved ? '0 : reload;
            update_d = 1'b0;
        end

        mag   = MAG_TBL[int'(bus.vol)*OUT_W +: OUT_W];
        snd_d = shift_q[0] ? $signed(mag) : -$signed(mag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= SEED;
            cnt_q      <= '0;
            update_q   <= 1'b0;
            last_ch2_q <= 1'b0;
            snd_q      <= '0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            update_q   <= update_d;
            last_ch2_q <= bus.ch2;
            snd_q      <= snd_d;
        end
    end

    assign bus.snd       = snd_q;
    assign bus.noise_bit = shift_q[0];
    assign bus.update    = update_q;
endmodule
